// File: rtl/multi_nbits_pipeline_if.sv
// Valid/ready bus of the pipelined multiplier: operand side and product side.
interface multi_nbits_pipeline_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] mul_out;

    // Producer of operands and consumer of products.
    modport master (
        output in_valid, mul_a, mul_b, out_ready,
        input  in_ready, out_valid, mul_out
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, mul_a, mul_b, out_ready,
        output in_ready, out_valid, mul_out
    );
endinterface

// File: rtl/multi_nbits_pipeline.sv
// Fully pipelined WIDTH x WIDTH array multiplier with valid/ready handshake.
// Stage 0 registers WIDTH partial products, each tree level halves the term
// count, and the final pairwise add is captured directly in the output
// register, giving a latency of 1 + log2(WIDTH) enabled edges.
// WIDTH must be a power of two and at least 2.
module multi_nbits_pipeline #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_nbits_pipeline_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int LOG2W = $clog2(WIDTH);
    localparam int LAT   = 1 + LOG2W;
    // Terms held in registers: WIDTH + WIDTH/2 + ... + 2.
    localparam int NTERM = 2 * WIDTH - 2;

    logic                      en;
    logic [PW-1:0]             a_ext;
    logic [NTERM-1:0][PW-1:0]  term_d;
    logic [NTERM-1:0][PW-1:0]  term_q;
    logic [LAT-2:0]            vld_q;
    logic [PW-1:0]             sum_d;
    logic [PW-1:0]             mul_out_q;
    logic                      out_valid_q;

    // One enable freezes the whole pipe while the output is held.
    assign en = !out_valid_q || bus.out_ready;

    // Multiplicand widened to product width in the selected number system.
    assign a_ext = SIGNED ? {{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a}
                          : {{WIDTH{1'b0}}, bus.mul_a};

    // Partial products; in signed mode the multiplier MSB carries weight
    // -2^(WIDTH-1), so its row is subtracted rather than added.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        logic [PW-1:0] pp;
        assign pp = bus.mul_b[i] ? (a_ext << i) : '0;
        if (SIGNED && (i == WIDTH - 1)) begin : g_neg
            assign term_d[i] = -pp;
        end else begin : g_pos
            assign term_d[i] = pp;
        end
    end

    // Adder-tree levels 1..LOG2W-1: each sums adjacent pairs of the level
    // below. Level k starts at flat offset 2*WIDTH - 2*(WIDTH >> k).
    for (genvar k = 1; k < LOG2W; k++) begin : g_lvl
        localparam int OFF_CUR = 2 * WIDTH - 2 * (WIDTH >> k);
        localparam int OFF_PRV = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
        for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_add
            assign term_d[OFF_CUR + j] = term_q[OFF_PRV + 2*j] + term_q[OFF_PRV + 2*j + 1];
        end
    end

    // Final tree level: the last two terms, summed straight into mul_out.
    assign sum_d = term_q[NTERM-2] + term_q[NTERM-1];

    // Pipeline registers, valid chain and output register, all gated by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the term array is a bank of pipeline flops, not a RAM, so it
            // is cleared with the rest of the state; reset discards in-flight work.
            term_q      <= '0;
            vld_q       <= '0;
            mul_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // stage's old value on the same edge, which is what makes it a pipe.
            term_q      <= term_d;
            vld_q       <= (vld_q << 1) | (LAT-1)'(bus.in_valid);
            out_valid_q <= vld_q[LAT-2];
            if (vld_q[LAT-2]) begin
                mul_out_q <= sum_d;
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.mul_out   = mul_out_q;
endmodule

// File: tb/tb_multi_nbits_pipeline.sv
// Self-checking bench: directed latency/stall/reset cases on small widths and a
// randomized valid/ready run on WIDTH=16 in both modes against a queue model.
module tb_multi_nbits_pipeline;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multi_nbits_pipeline_if #(.WIDTH(4))  if4  ();
    multi_nbits_pipeline_if #(.WIDTH(8))  if8s ();
    multi_nbits_pipeline_if #(.WIDTH(8))  if8u ();
    multi_nbits_pipeline_if #(.WIDTH(16)) if16u ();
    multi_nbits_pipeline_if #(.WIDTH(16)) if16s ();

    multi_nbits_pipeline #(.WIDTH(4),  .SIGNED(1'b0)) u4   (.clk(clk), .rst_n(rst_n), .bus(if4));
    multi_nbits_pipeline #(.WIDTH(8),  .SIGNED(1'b1)) u8s  (.clk(clk), .rst_n(rst_n), .bus(if8s));
    multi_nbits_pipeline #(.WIDTH(8),  .SIGNED(1'b0)) u8u  (.clk(clk), .rst_n(rst_n), .bus(if8u));
    multi_nbits_pipeline #(.WIDTH(16), .SIGNED(1'b0)) u16u (.clk(clk), .rst_n(rst_n), .bus(if16u));
    multi_nbits_pipeline #(.WIDTH(16), .SIGNED(1'b1)) u16s (.clk(clk), .rst_n(rst_n), .bus(if16s));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference products, straight from the arithmetic definition.
    function automatic logic [31:0] ref_u16(input logic [15:0] a, input logic [15:0] b);
        longint unsigned pa = a;
        longint unsigned pb = b;
        return 32'(pa * pb);
    endfunction

    function automatic logic [31:0] ref_s16(input logic [15:0] a, input logic [15:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [3:0]  t2_a[4]   = '{4'd3, 4'd4, 4'd3, 4'd15};
    logic [3:0]  t2_b[4]   = '{4'd5, 4'd4, 4'd4, 4'd15};
    logic [7:0]  t2_e[4]   = '{8'd15, 8'd16, 8'd12, 8'd225};
    logic [7:0]  t3_a[4]   = '{8'hFD, 8'h80, 8'h80, 8'hFF};
    logic [7:0]  t3_b[4]   = '{8'h05, 8'h80, 8'h7F, 8'hFF};
    logic [15:0] t3_e[4]   = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0001};
    logic [31:0] q_u[$];
    logic [31:0] q_s[$];

    initial begin
        if4.in_valid  = 1'b0; if4.out_ready  = 1'b1; if4.mul_a  = '0; if4.mul_b  = '0;
        if8s.in_valid = 1'b0; if8s.out_ready = 1'b1; if8s.mul_a = '0; if8s.mul_b = '0;
        if8u.in_valid = 1'b0; if8u.out_ready = 1'b1; if8u.mul_a = '0; if8u.mul_b = '0;
        if16u.in_valid = 1'b0; if16u.out_ready = 1'b1; if16u.mul_a = '0; if16u.mul_b = '0;
        if16s.in_valid = 1'b0; if16s.out_ready = 1'b1; if16s.mul_a = '0; if16s.mul_b = '0;

        // Reset state while rst_n is low.
        #12;
        check("rst_in_ready", if4.in_ready, 1'b1);
        check("rst_out_valid", if4.out_valid, 1'b0);
        check("rst_mul_out", if4.mul_out, 8'h00);
        check("rst_mul_out_w16", if16s.mul_out, 32'h0);

        // W4: 3x5 accepted on the first edge after release; visible after edge t+2.
        @(negedge clk);
        rst_n = 1'b1;
        if4.in_valid = 1'b1; if4.mul_a = 4'd3; if4.mul_b = 4'd5;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if4.in_valid = 1'b0;
            end
            #1;
            if (c == 0) check("t1_in_ready", if4.in_ready, 1'b1);
            check($sformatf("t1_valid_c%0d", c), if4.out_valid, c == 3);
            if (c == 3) check("t1_product", if4.mul_out, 8'h0F);
        end

        // W4: back-to-back operands come out back-to-back.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                if4.in_valid = 1'b1; if4.mul_a = t2_a[c]; if4.mul_b = t2_b[c];
            end else begin
                if4.in_valid = 1'b0;
            end
            #1;
            check($sformatf("t2_valid_c%0d", c), if4.out_valid, (c >= 3) && (c <= 6));
            if (c >= 3 && c <= 6) check($sformatf("t2_product_%0d", c - 3), if4.mul_out, t2_e[c-3]);
        end

        // W8 signed corner products, latency 4.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 4) begin
                if8s.in_valid = 1'b1; if8s.mul_a = t3_a[c]; if8s.mul_b = t3_b[c];
            end else begin
                if8s.in_valid = 1'b0;
            end
            #1;
            check($sformatf("t3_valid_c%0d", c), if8s.out_valid, (c >= 4) && (c <= 7));
            if (c >= 4 && c <= 7) check($sformatf("t3_product_%0d", c - 4), if8s.mul_out, t3_e[c-4]);
        end

        // W8 unsigned stall: 255x255 held for four cycles, then 2x3 follows.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if8u.in_valid  = (c < 2);
            if8u.mul_a     = (c == 0) ? 8'd255 : 8'd2;
            if8u.mul_b     = (c == 0) ? 8'd255 : 8'd3;
            if8u.out_ready = !((c >= 4) && (c <= 7));
            #1;
            check($sformatf("t4_valid_c%0d", c), if8u.out_valid, (c >= 4) && (c <= 9));
            check($sformatf("t4_in_ready_c%0d", c), if8u.in_ready, !((c >= 4) && (c <= 7)));
            if (c >= 4 && c <= 8) check($sformatf("t4_hold_c%0d", c), if8u.mul_out, 16'hFE01);
            if (c == 9) check("t4_second", if8u.mul_out, 16'h0006);
        end

        // W4 reset mid-operation with three products in flight.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if4.in_valid = (c < 3);
            if4.mul_a = 4'(c + 5); if4.mul_b = 4'(c + 5);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", if4.out_valid, 1'b0);
        check("t5_rst_mul_out", if4.mul_out, 8'h00);
        check("t5_rst_in_ready", if4.in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        if4.in_valid = 1'b1; if4.mul_a = 4'd7; if4.mul_b = 4'd9;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if4.in_valid = 1'b0;
            end
            #1;
            check($sformatf("t5_valid_c%0d", c), if4.out_valid, c == 3);
            if (c == 3) check("t5_product", if4.mul_out, 8'd63);
        end

        // W16 randomized handshake in both modes against the queue model;
        // the tail phase drains with in_valid low and out_ready high.
        for (int c = 0; c < 3040; c++) begin
            @(negedge clk);
            if16u.in_valid  = (c < 3000) && ($urandom_range(0, 3) != 0);
            if16u.out_ready = (c >= 3000) || ($urandom_range(0, 3) != 0);
            if16u.mul_a = rnd16(); if16u.mul_b = rnd16();
            if16s.in_valid  = (c < 3000) && ($urandom_range(0, 3) != 0);
            if16s.out_ready = (c >= 3000) || ($urandom_range(0, 3) != 0);
            if16s.mul_a = rnd16(); if16s.mul_b = rnd16();
            #1;
            check("rnd_u_in_ready", if16u.in_ready, !if16u.out_valid || if16u.out_ready);
            check("rnd_s_in_ready", if16s.in_ready, !if16s.out_valid || if16s.out_ready);
            if (if16u.out_valid && if16u.out_ready) begin
                if (q_u.size() == 0) check("rnd_u_spurious", if16u.out_valid, 1'b0);
                else check("rnd_u_product", if16u.mul_out, q_u.pop_front());
            end
            if (if16s.out_valid && if16s.out_ready) begin
                if (q_s.size() == 0) check("rnd_s_spurious", if16s.out_valid, 1'b0);
                else check("rnd_s_product", if16s.mul_out, q_s.pop_front());
            end
            if (if16u.in_valid && if16u.in_ready) q_u.push_back(ref_u16(if16u.mul_a, if16u.mul_b));
            if (if16s.in_valid && if16s.in_ready) q_s.push_back(ref_s16(if16s.mul_a, if16s.mul_b));
        end
        check("rnd_u_lost", 64'(q_u.size()), 64'd0);
        check("rnd_s_lost", 64'(q_s.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
